// File: rtl/z_det_pkg.sv
// Shared definitions for the z_seq_detector slice: state encodings,
// the state type and the recognised pattern.
package z_det_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE  = 3'b000;
  localparam state_t G1    = 3'b001;
  localparam state_t G10   = 3'b010;
  localparam state_t G101  = 3'b011;
  localparam state_t G1011 = 3'b100;

  // Documentation only: the FSM transitions below are hand-coded for 1-0-1-1.
  localparam logic [3:0] PATTERN = 4'b1011;

endpackage

// File: rtl/z_seq_detector_sat_counter.sv
// Saturating up-counter with synchronous clear, used for the match count.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (inc && (count_reg != CNT_MAX)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/z_seq_detector.sv
// Serial 1-0-1-1 detector on the decoder's z stream with match pulse and
// saturating match count. Z_DET_OVERLAP_EN selects overlapping detection.
module z_seq_detector
  import z_det_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             z_valid,
  input  logic             z,
  input  logic             clear,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic [2:0]       state_code
);

  state_t state_reg;
  state_t state_next;
  logic   match_reg;
  logic   accept;

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    if (clear) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:  if (z_valid) state_next = z ? G1 : IDLE;
        G1:    if (z_valid) state_next = z ? G1 : G10;
        G10:   if (z_valid) state_next = z ? G101 : IDLE;
        G101: begin
          if (z_valid) begin
            state_next = z ? G1011 : G10;
            accept     = z;
          end
        end
`ifdef Z_DET_OVERLAP_EN
        G1011: if (z_valid) state_next = z ? G1 : G10;
`else
        G1011: if (z_valid) state_next = z ? G1 : IDLE;
`endif
        // Illegal encodings recover unconditionally, without a match.
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      match_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      match_reg <= accept;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_sat_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .inc   (accept),
    .count (match_count)
  );

  assign match      = match_reg;
  assign state_code = state_reg;

endmodule

// File: doc/z_seq_detector.md
# z_seq_detector

Serial pattern detector that sits directly downstream of the 3-input minterm decoder and consumes its `z` output one bit per qualified clock. It recognises the fixed bit sequence 1-0-1-1, with the first-arriving bit first. It emits a one-cycle match pulse, keeps a saturating count of matches, and exposes its 3-bit state code for debug and for reuse by the next decoder stage.

## Interface
- `CNT_W`, default 8: width of the match counter; legal range 2 to 16.
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `z_valid`  in  1  high when `z` carries a new sample this cycle.
- `z`  in  1  serial data bit from the decoder.
- `clear`  in  1  synchronous clear of the FSM and the counter.
- `match`  out  1  registered one-cycle pulse on pattern completion.
- `match_count`  out  CNT_W  saturating number of matches since reset or clear.
- `state_code`  out  3  current FSM state encoding.

## Operation
- The FSM is Moore-style with registered outputs and five states:
  - IDLE=3'b000: no prefix seen.
  - G1=3'b001: "1" seen.
  - G10=3'b010: "10" seen.
  - G101=3'b011: "101" seen.
  - G1011=3'b100: full pattern just seen.
- Transitions occur only on edges where `z_valid`=1; otherwise all registers hold.
  - IDLE: z=1 goes to G1; z=0 stays in IDLE.
  - G1: z=1 stays in G1; z=0 goes to G10.
  - G10: z=1 goes to G101; z=0 goes to IDLE.
  - G101: z=1 goes to G1011 (accepting); z=0 goes to G10 (the suffix "10" is retained).
  - G1011: behaviour is set by the macro; see Configuration.
- Accepting edge: the edge taking the FSM into G1011.
  - On that edge `match` is set to 1. On every other edge it is cleared to 0.
  - On that edge `match_count` increments by 1, unless it already equals 2^CNT_W−1, in which case it holds.
- `clear`=1 on an edge forces `state_code`=IDLE, `match`=0 and `match_count`=0. `clear` overrides `z_valid` on the same edge.
- Unused encodings 3'b101 to 3'b111 return to IDLE on the next edge, regardless of `z_valid`. No match is produced on that edge.

## Timing
- Reset values while `rst_n`=0: `state_code`=3'b000, `match`=0, `match_count`=0. Reset is asynchronous: outputs clear without waiting for a clock edge.
- Reset deasserted mid-pattern: all previously received bits are lost; detection restarts from IDLE.
- Latency: `match` goes high in the cycle immediately after the edge that samples the final "1". It stays high for exactly one cycle, even if `z_valid` then drops.
- `match_count` updates on the same edge as `match`, so both are visible in the same cycle.
- No backpressure: a sample is consumed on every edge where `z_valid`=1. There is no stall.
- A `z_valid` gap of any length between bits does not break a partial match.

## Configuration
- Macro `Z_DET_OVERLAP_EN`.
- Defined (overlapping detection): from G1011, z=1 goes to G1 and z=0 goes to G10. For the stream 1011011 this yields two matches.
- Undefined (non-overlapping): from G1011, z=1 goes to G1 and z=0 goes to IDLE. For the same stream 1011011 this yields one match.
- All other transitions are identical in both builds.

## Structure
- Shared package `z_det_pkg` holds:
  - the state-encoding constants IDLE, G1, G10, G101 and G1011;
  - the 3-bit state typedef;
  - the pattern constant 4'b1011, which is documentation only because transitions are hand-coded.
- One sub-module, `sat_counter`, parameterised by CNT_W, with inputs `inc` and `clr`. It implements `match_count`.
- The FSM and the `match` register live in the top module.

## Test plan
- Reset: pulse `rst_n` low asynchronously mid-cycle → all outputs 0 immediately. After release, stream 1,0,1,1 → `match`=1 for one cycle, `match_count`=1.
- Overlap: stream 1,0,1,1,0,1,1, with `z_valid`=1 throughout.
  - With `Z_DET_OVERLAP_EN` defined → matches after bits 4 and 7, final `match_count`=2.
  - Without the macro → one match only, final `match_count`=1.
- Partial-prefix recovery: stream 1,0,1,0,1,1 → a single match after the 6th bit. This covers the G101 to G10 transition on z=0.
- Valid gaps: send 1,0,1,1 with 3 idle cycles (`z_valid`=0) between each bit → exactly one match. `state_code` holds its value during the gaps.
- Saturation: with CNT_W=2, send the pattern 5 times → `match_count` sequence 1,2,3,3,3, and `match` pulses 5 times.
- Clear priority: assert `clear`=1 on the same edge as the final "1" of the pattern → `match`=0, `match_count`=0, `state_code`=IDLE.
